mux_rr_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares one output channel between four producers, driving the 4:1 select internally. It has a registered output stage and valid/ready handshakes on both sides. Multi-beat packets (framed by `last`) hold the grant until the final beat. It sits in front of any shared consumer, for example a single bus or FIFO write port.

---
 rtl/mux_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with an internal 4:1 data select and a
// registered output stage. Multi-beat packets keep the grant until the beat
// marked last, and the rotating priority pointer moves only at packet ends.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, owner_q;
  logic [1:0]       gnt, idx;
  logic             gnt_valid;
  logic             can_load;
  logic             accept;
  logic [WIDTH-1:0] gnt_data;

  assign can_load = !out_valid || out_ready;
  assign accept   = gnt_valid && in_valid[gnt] && can_load;

  // Pick the granted requester: packet owner when locked, else first valid
  // from ptr upward. The loop runs downward so the lowest offset wins.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    if (state_q == StLocked) begin
      gnt       = owner_q;
      gnt_valid = 1'b1;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr_q + 2'(k);
        if (in_valid[idx]) begin
          gnt       = idx;
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // Select data from the granted input only, so X on other inputs is ignored.
  always_comb begin
    gnt_data = '0;
    unique case (gnt)
      2'd0: gnt_data = d0;
      2'd1: gnt_data = d1;
      2'd2: gnt_data = d2;
      2'd3: gnt_data = d3;
      default: gnt_data = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a non-last beat locks onto its requester, a last beat frees it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last[gnt] ? StArb : StLocked;
    end
  end

  // FSM outputs: ready only to the granted requester; forced low in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_valid && can_load) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // Priority pointer and packet owner bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else if (accept) begin
      if (in_last[gnt]) begin
        ptr_q <= gnt + 2'd1;
      end else begin
        owner_q <= gnt;
      end
    end
  end

  // Output register: load on accept, drain when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_last  <= in_last[gnt];
      out_sel   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus constrained-random traffic,
// every cycle compared against a packet-level reference model.
module tb_mux_rr_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_valid, in_last;
  logic [WIDTH-1:0] dv [4];
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       in_ready;
  logic             out_valid, out_last, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  assign d0 = dv[0];
  assign d1 = dv[1];
  assign d2 = dv[2];
  assign d3 = dv[3];

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the channel, where priority starts, and what
  // the consumer should currently see.
  bit               m_locked;
  int               m_owner, m_ptr;
  bit               m_ov, m_ol;
  logic [WIDTH-1:0] m_od;
  int               m_os;
  int               acc_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_last",  32'(out_last),  32'(m_ol));
    check("out_sel",   32'(out_sel),   32'(m_os));
  endtask

  // One clock: check in_ready against the model grant, step the model across
  // the edge and check the registered outputs.
  task automatic run_cycle();
    int   g;
    bit   has, can_load, acc;
    logic [3:0] exp_ready;
    #1;
    has = 0; g = 0;
    if (m_locked) begin
      has = 1; g = m_owner;
    end else begin
      for (int k = 0; k < 4 && !has; k++) begin
        if (in_valid[(m_ptr + k) % 4]) begin
          has = 1; g = (m_ptr + k) % 4;
        end
      end
    end
    can_load  = !m_ov || out_ready;
    exp_ready = (has && can_load) ? 4'(1 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = has && in_valid[g] && can_load;
    @(posedge clk);
    #1;
    acc_idx = -1;
    if (acc) begin
      acc_idx = g;
      m_ov = 1; m_od = dv[g]; m_ol = in_last[g]; m_os = g;
      if (in_last[g]) begin
        m_ptr = (g + 1) % 4; m_locked = 0;
      end else begin
        m_owner = g; m_locked = 1;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_last = '0;
    for (int i = 0; i < 4; i++) dv[i] = '0;
    model_reset();
    #3;
    do_reset();

    // Single beat from requester 2.
    in_valid = 4'b0100; in_last = 4'b0100; dv[2] = 4'hc;
    run_cycle();
    check("single_sel", 32'(out_sel), 32'd2);
    check("single_data", 32'(out_data), 32'hc);
    in_valid = '0;
    run_cycle();
    do_reset();

    // Round robin: four single-beat requesters, out_ready held high.
    in_valid = 4'b1111; in_last = 4'b1111;
    dv[0] = 4'ha; dv[1] = 4'hb; dv[2] = 4'hc; dv[3] = 4'hd;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("rr_sel", 32'(out_sel), 32'(i % 4));
      check("rr_data", 32'(out_data), 32'(4'ha + 4'(i % 4)));
    end

    // Backpressure while the output register is full.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
    check("bp_hold_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b1;
    run_cycle();
    check("bp_resume_sel", 32'(out_sel), 32'd1);

    // Reset mid-run with every requester valid, then first grant is 0.
    #2;
    do_reset();
    #1;
    check("post_rst_grant", 32'(in_ready), 32'b0001);
    in_valid = '0;
    run_cycle();

    // Packet lock: 3-beat packet from requester 1 holds off 0 and 2.
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000; dv[1] = 4'h1;
    run_cycle();
    in_valid = 4'b0111; in_last = 4'b0101; dv[0] = 4'h7; dv[2] = 4'h5; dv[1] = 4'h2;
    run_cycle();
    dv[1] = 4'h3; in_last = 4'b0111;
    run_cycle();
    check("lock_sel3", 32'(out_sel), 32'd1);
    in_valid = 4'b0101;
    run_cycle();
    check("lock_sel4", 32'(out_sel), 32'd2);
    check("lock_data4", 32'(out_data), 32'h5);
    in_valid = 4'b0001;
    run_cycle();
    check("lock_sel5", 32'(out_sel), 32'd0);
    check("lock_data5", 32'(out_data), 32'h7);

    // X on an idle requester never reaches out_data.
    in_valid = 4'b0111; in_last = 4'b1111; dv[3] = 'x;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("x_free", 32'($isunknown(out_data)), 32'd0);
    end

    // Reset while requester 2 owns a packet; afterwards 0 wins over 2.
    dv[3] = '0;
    in_valid = 4'b0100; in_last = 4'b0000;
    run_cycle();
    #2;
    do_reset();
    in_valid = 4'b0101; in_last = 4'b0101;
    #1;
    check("rst_lock_grant", 32'(in_ready), 32'b0001);
    run_cycle();

    // Random traffic; a requester changes its beat only once it is accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_idx == i || !in_valid[i]) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          in_last[i]  = ($urandom_range(0, 2) != 0);
          dv[i]       = WIDTH'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
